mmio_gpio_ctrl: RTL
===================

Name: mmio_gpio_ctrl

Overview:
- Memory-mapped GPIO controller for the single-cycle MIPS core's IO address window.
- Debounces two push-buttons and snapshots a parametrised switch bank on a "capture" press.
- Double-buffers the LED output: staged by CPU write, committed on a "commit" press.
- Exposes sticky W1C status (done / valid / overrun), per-bit interrupt enables and a registered irq line to the core.

Parameters:
- SW_WIDTH, 16, switch bank width; 1..32; SW_BYTES = ceil(SW_WIDTH/8).
- LED_WIDTH, 12, LED output width; 1..32.
- DATA_WIDTH, 32, bus data width.
- ADDR_WIDTH, 3, word address width; must satisfy 4+SW_BYTES <= 2**ADDR_WIDTH.
- DEBOUNCE_CYCLES, 20000, consecutive stable cycles required to accept a button level change; >= 1.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- pread  in  1  bus read strobe.
- pwrite  in  1  bus write strobe.
- addr  in  ADDR_WIDTH  register word address.
- pwritedata  in  DATA_WIDTH  write data.
- preaddata  out  DATA_WIDTH  read data, combinational.
- irq  out  1  level interrupt, registered.
- buttonl  in  1  raw async "commit LED" button.
- buttonr  in  1  raw async "capture switches" button.
- switch  in  SW_WIDTH  raw async switches.
- led  out  LED_WIDTH  committed LED value.

Behaviour:
- Register map (word addr):
  - 0 STATUS, R/W1C: bit0 LED_DONE, bit1 SW_VALID, bit2 SW_OVERRUN.
  - 1 LED_STAGE, R/W, LED_WIDTH bits.
  - 2 IRQ_EN, R/W, bits[2:0].
  - 3 LED_OUT, R.
  - 4..4+SW_BYTES-1: switch snapshot byte k = snap[8k+7:8k], zero-extended; unused top bits read 0.
  - Unmapped addresses: read 0, writes ignored.
- Read path: preaddata = selected register when pread=1, else 0. Same-cycle combinational; reads have no side effects.
- Write path: takes effect at the clock edge when pwrite=1. Narrow registers use the low bits of pwritedata.
- Reset: all registers, led, irq, synchronizers, debounce counters and pulses go to 0.
- Switch synchronizer: switch passes through 2 flops; the snapshot samples the synchronized value.
- Button debounce, per button:
  - 2-flop synchronizer producing s2, debounced level db, counter cnt.
  - Each edge with s2 != db: if cnt == DEBOUNCE_CYCLES-1 then db <= s2 and cnt <= 0; else cnt++.
  - s2 == db: cnt <= 0.
  - press pulse is registered: high for exactly 1 cycle, the cycle after db rises. Release produces no pulse.
  - A raw high held from edge 0 gives db=1 after edge DEBOUNCE_CYCLES+2, pulse after edge DEBOUNCE_CYCLES+3, and the status effect after edge DEBOUNCE_CYCLES+4.
  - Glitches shorter than DEBOUNCE_CYCLES cycles after sync produce no pulse.
- Commit pulse: led <= LED_STAGE (value before any same-cycle write); LED_DONE <= 1.
- Capture pulse: snap <= synced switch.
  - If SW_VALID is already 1, SW_OVERRUN <= 1.
  - SW_VALID <= 1.
- CPU write to LED_STAGE: clears LED_DONE.
- STATUS write: each bit with pwritedata=1 clears; 0 bits are unaffected.
- Simultaneous events (same cycle):
  - Hardware set beats W1C clear and beats the LED_STAGE-write clear.
  - A commit pulse with a LED_STAGE write drives led to the old stage; the stage takes the new value and LED_DONE ends at 1.
- irq <= |(STATUS & IRQ_EN), updated each edge, so it lags status by 1 cycle.
- Reset mid-debounce discards partial counts; a button still held after reset must complete a full debounce before it pulses.

Decomposition:
- Package gpio_pkg:
  - Address localparams ADDR_STATUS=0, ADDR_LED_STAGE=1, ADDR_IRQ_EN=2, ADDR_LED_OUT=3, ADDR_SW_BASE=4.
  - Status bit indices ST_LED_DONE=0, ST_SW_VALID=1, ST_SW_OVERRUN=2.
- Sub-module gpio_debounce (params DEBOUNCE_CYCLES; ports clk, reset, raw, level, press_pulse), instantiated twice. Counter width is $clog2(DEBOUNCE_CYCLES+1).

Test Plan:
- Reset, then read addrs 0..7 -> all return 0; led=0, irq=0.
- DEBOUNCE_CYCLES=4: write LED_STAGE=0xABC, hold buttonl high from edge 0 -> led=0xABC and STATUS=0x1 after edge 8; press pulse high for exactly 1 cycle; a further write of 0x123 -> STATUS=0x0, led still 0xABC.
- switch=0xBEEF, press buttonr -> addr4 reads 0xEF, addr5 reads 0xBE, STATUS=0x2; switch=0x1234 with a second press -> addr5 reads 0x12, STATUS=0x6; write STATUS 0x6 -> 0x0.
- buttonr pulse of 3 cycles with DEBOUNCE_CYCLES=4 -> no capture, STATUS stays 0; bounce 1-0-1-0 then a steady high -> exactly one capture.
- IRQ_EN=0x2, capture -> irq=1 one cycle after SW_VALID sets; W1C bit1 in the same cycle as a new capture pulse -> SW_VALID stays 1, SW_OVERRUN=1, irq stays 1.
- Assert reset during a half-completed debounce count -> no pulse follows; a button held through reset pulses only DEBOUNCE_CYCLES+3 cycles after reset deasserts.

Source files
------------

// File: rtl/gpio_pkg.sv
// Shared register map and status bit positions for the MMIO GPIO block.
package gpio_pkg;

    localparam int ADDR_STATUS    = 0;
    localparam int ADDR_LED_STAGE = 1;
    localparam int ADDR_IRQ_EN    = 2;
    localparam int ADDR_LED_OUT   = 3;
    localparam int ADDR_SW_BASE   = 4;

    localparam int ST_LED_DONE    = 0;
    localparam int ST_SW_VALID    = 1;
    localparam int ST_SW_OVERRUN  = 2;

    function automatic int byte_count(input int bits);
        return (bits + 7) / 8;
    endfunction

endpackage

// File: rtl/gpio_debounce.sv
// Button synchronizer + stable-count debouncer with a one-cycle press pulse.
module gpio_debounce #(
    parameter int DEBOUNCE_CYCLES = 20000
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    output logic level,
    output logic press_pulse
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          s1;
    logic          s2;
    logic          db;
    logic          db_d;
    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            s1          <= 1'b0;
            s2          <= 1'b0;
            db          <= 1'b0;
            db_d        <= 1'b0;
            cnt         <= '0;
            press_pulse <= 1'b0;
        end else begin
            s1          <= raw;
            s2          <= s1;
            db_d        <= db;
            press_pulse <= db & ~db_d;
            // Count only while the synced level disagrees with the accepted one
            if (s2 != db) begin
                if (cnt == CNT_LAST) begin
                    db  <= s2;
                    cnt <= '0;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end else begin
                cnt <= '0;
            end
        end
    end

    assign level = db;

endmodule

// File: rtl/mmio_gpio_ctrl.sv
// MMIO GPIO controller: debounced commit/capture buttons, staged LEDs,
// switch snapshot, sticky W1C status and a registered interrupt.
module mmio_gpio_ctrl
    import gpio_pkg::*;
#(
    parameter int SW_WIDTH        = 16,
    parameter int LED_WIDTH       = 12,
    parameter int DATA_WIDTH      = 32,
    parameter int ADDR_WIDTH      = 3,
    parameter int DEBOUNCE_CYCLES = 20000
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  pread,
    input  logic                  pwrite,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] pwritedata,
    output logic [DATA_WIDTH-1:0] preaddata,
    output logic                  irq,
    input  logic                  buttonl,
    input  logic                  buttonr,
    input  logic [SW_WIDTH-1:0]   switch,
    output logic [LED_WIDTH-1:0]  led
);

    localparam int SW_BYTES = byte_count(SW_WIDTH);
    localparam int SNAP_W   = SW_BYTES * 8;

    logic [SW_WIDTH-1:0]  sw_s1;
    logic [SW_WIDTH-1:0]  sw_s2;
    logic [SW_WIDTH-1:0]  snap;
    logic [SNAP_W-1:0]    snap_pad;
    logic [LED_WIDTH-1:0] stage;
    logic [2:0]           status;
    logic [2:0]           status_nxt;
    logic [2:0]           irq_en;
    logic                 commit;
    logic                 capture;
    logic                 wr_status;
    logic                 wr_stage;
    logic                 wr_en;
    logic                 unused_lvl_l;
    logic                 unused_lvl_r;
    logic                 unused_wdata;

    gpio_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_commit (
        .clk        (clk),
        .reset      (reset),
        .raw        (buttonl),
        .level      (unused_lvl_l),
        .press_pulse(commit)
    );

    gpio_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_capture (
        .clk        (clk),
        .reset      (reset),
        .raw        (buttonr),
        .level      (unused_lvl_r),
        .press_pulse(capture)
    );

    assign unused_wdata = ^pwritedata;

    assign wr_status = pwrite && (addr == ADDR_WIDTH'(ADDR_STATUS));
    assign wr_stage  = pwrite && (addr == ADDR_WIDTH'(ADDR_LED_STAGE));
    assign wr_en     = pwrite && (addr == ADDR_WIDTH'(ADDR_IRQ_EN));

    // Clears are applied first so hardware sets always win
    always_comb begin
        status_nxt = status;
        if (wr_status) begin
            status_nxt = status & ~pwritedata[2:0];
        end
        if (wr_stage) begin
            status_nxt[ST_LED_DONE] = 1'b0;
        end
        if (commit) begin
            status_nxt[ST_LED_DONE] = 1'b1;
        end
        if (capture) begin
            status_nxt[ST_SW_VALID] = 1'b1;
            if (status[ST_SW_VALID]) begin
                status_nxt[ST_SW_OVERRUN] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sw_s1  <= '0;
            sw_s2  <= '0;
            snap   <= '0;
            stage  <= '0;
            led    <= '0;
            irq_en <= '0;
            status <= '0;
            irq    <= 1'b0;
        end else begin
            sw_s1  <= switch;
            sw_s2  <= sw_s1;
            status <= status_nxt;
            irq    <= |(status & irq_en);
            if (wr_stage) begin
                stage <= pwritedata[LED_WIDTH-1:0];
            end
            if (wr_en) begin
                irq_en <= pwritedata[2:0];
            end
            if (commit) begin
                led <= stage;
            end
            if (capture) begin
                snap <= sw_s2;
            end
        end
    end

    assign snap_pad = SNAP_W'(snap);

    always_comb begin
        preaddata = '0;
        if (pread) begin
            if (addr == ADDR_WIDTH'(ADDR_STATUS)) begin
                preaddata = DATA_WIDTH'(status);
            end else if (addr == ADDR_WIDTH'(ADDR_LED_STAGE)) begin
                preaddata = DATA_WIDTH'(stage);
            end else if (addr == ADDR_WIDTH'(ADDR_IRQ_EN)) begin
                preaddata = DATA_WIDTH'(irq_en);
            end else if (addr == ADDR_WIDTH'(ADDR_LED_OUT)) begin
                preaddata = DATA_WIDTH'(led);
            end else begin
                for (int k = 0; k < SW_BYTES; k++) begin
                    if (addr == ADDR_WIDTH'(ADDR_SW_BASE + k)) begin
                        preaddata = DATA_WIDTH'(snap_pad[8*k +: 8]);
                    end
                end
            end
        end
    end

endmodule
